// File: rtl/ex_mem_stage_pkg.sv
// Shared constants for the execute stage: ALU op encodings, thread-id width and the bubble control word.
package ex_mem_stage_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_REG_W   = 5;
    localparam int DEF_THREADS = 4;
    localparam int THREAD_W    = $clog2(DEF_THREADS);

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef struct packed {
        logic wreg_en;
        logic wmem_en;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{wreg_en: 1'b0, wmem_en: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX-to-EX/MEM bundle; master drives the ID/EX side and perf controls, slave is the execute stage.
interface ex_mem_stage_if #(
    parameter int DW = 16,
    parameter int RW = 5,
    parameter int TW = 2
);
    logic          valid_in;
    logic          stall;
    logic          flush;
    logic          WRegEn_in;
    logic          WMemEn_in;
    logic          alu_src_in;
    logic          mem_to_reg_in;
    logic [DW-1:0] R1out_in;
    logic [DW-1:0] R2out_in;
    logic [DW-1:0] sign_ext_in;
    logic [RW-1:0] WReg1_in;
    logic [2:0]    func3_in;
    logic          func7_in;
    logic [TW-1:0] thread_id_in;
    logic          valid_out;
    logic [DW-1:0] alu_result_out;
    logic [DW-1:0] store_data_out;
    logic          WRegEn_out;
    logic          WMemEn_out;
    logic          mem_to_reg_out;
    logic [RW-1:0] WReg1_out;
    logic [TW-1:0] thread_id_out;
    logic [TW-1:0] perf_sel;
    logic          perf_clr;
    logic [15:0]   perf_count;

    modport master (
        output valid_in, stall, flush, WRegEn_in, WMemEn_in, alu_src_in, mem_to_reg_in,
               R1out_in, R2out_in, sign_ext_in, WReg1_in, func3_in, func7_in, thread_id_in,
               perf_sel, perf_clr,
        input  valid_out, alu_result_out, store_data_out, WRegEn_out, WMemEn_out,
               mem_to_reg_out, WReg1_out, thread_id_out, perf_count
    );

    modport slave (
        input  valid_in, stall, flush, WRegEn_in, WMemEn_in, alu_src_in, mem_to_reg_in,
               R1out_in, R2out_in, sign_ext_in, WReg1_in, func3_in, func7_in, thread_id_in,
               perf_sel, perf_clr,
        output valid_out, alu_result_out, store_data_out, WRegEn_out, WMemEn_out,
               mem_to_reg_out, WReg1_out, thread_id_out, perf_count
    );
endinterface

// File: rtl/ex_mem_stage_alu.sv
// Combinational ALU of the execute stage; result wraps mod 2^DW and produces no flags.
module ex_alu
    import ex_mem_stage_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] opa_i,
    input  logic [DW-1:0] opb_i,
    input  logic [2:0]    func3_i,
    input  logic          func7_i,
    input  logic          alu_src_i,
    output logic [DW-1:0] result_o
);
    localparam int SHW = $clog2(DW);

    logic [SHW-1:0]       shamt_s;
    logic signed [DW-1:0] sra_s;

    assign shamt_s = opb_i[SHW-1:0];
    // Kept as its own signed expression so the arithmetic shift is not demoted to logical.
    assign sra_s   = $signed(opa_i) >>> shamt_s;

    // Operation select; subtract only exists for register-register adds.
    always_comb begin
        result_o = {DW{1'b0}};
        case (func3_i)
            ALU_ADD: begin
                if (func7_i && !alu_src_i) begin
                    result_o = opa_i - opb_i;
                end else begin
                    result_o = opa_i + opb_i;
                end
            end
            ALU_SLL:  result_o = opa_i << shamt_s;
            ALU_SLT:  result_o = {{(DW-1){1'b0}}, ($signed(opa_i) < $signed(opb_i))};
            ALU_SLTU: result_o = {{(DW-1){1'b0}}, (opa_i < opb_i)};
            ALU_XOR:  result_o = opa_i ^ opb_i;
            ALU_SRL: begin
                if (func7_i) begin
                    result_o = sra_s;
                end else begin
                    result_o = opa_i >> shamt_s;
                end
            end
            ALU_OR:   result_o = opa_i | opb_i;
            ALU_AND:  result_o = opa_i & opb_i;
            default:  result_o = {DW{1'b0}};
        endcase
    end
endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM register with flush > stall > load priority.
// Optional per-thread retire counters are built when EX_PERF_CNT_EN is defined.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int PROC_DATA_WIDTH        = DEF_DATA_W,
    parameter int PROC_REGFILE_LOG2_DEEP = DEF_REG_W,
    parameter int THREADS                = DEF_THREADS
) (
    input  logic          CLK,
    input  logic          RST_N,
    ex_mem_stage_if.slave bus
);
    localparam int DW = PROC_DATA_WIDTH;
    localparam int RW = PROC_REGFILE_LOG2_DEEP;
    localparam int TW = $clog2(THREADS);

    logic [DW-1:0] opb_s;
    logic [DW-1:0] alu_s;
    logic          load_s;

    logic          valid_q, valid_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic [DW-1:0] alu_q, alu_d;
    logic [DW-1:0] store_q, store_d;
    logic [RW-1:0] wreg_q, wreg_d;
    logic [TW-1:0] tid_q, tid_d;

    assign opb_s  = bus.alu_src_in ? bus.sign_ext_in : bus.R2out_in;
    assign load_s = bus.valid_in & ~bus.flush & ~bus.stall;

    ex_alu #(.DW(DW)) u_alu (
        .opa_i     (bus.R1out_in),
        .opb_i     (opb_s),
        .func3_i   (bus.func3_in),
        .func7_i   (bus.func7_in),
        .alu_src_i (bus.alu_src_in),
        .result_o  (alu_s)
    );

    // Next EX/MEM contents: bubbles clear valid/control but leave the data registers untouched.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        store_d = store_q;
        wreg_d  = wreg_q;
        tid_d   = tid_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
        end else if (bus.stall) begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
        end else if (bus.valid_in) begin
            valid_d            = 1'b1;
            ctrl_d.wreg_en     = bus.WRegEn_in & (bus.WReg1_in != {RW{1'b0}});
            ctrl_d.wmem_en     = bus.WMemEn_in;
            ctrl_d.mem_to_reg  = bus.mem_to_reg_in;
            alu_d              = alu_s;
            store_d            = bus.R2out_in;
            wreg_d             = bus.WReg1_in;
            tid_d              = bus.thread_id_in;
        end else begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
        end
    end

    // EX/MEM pipeline register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            alu_q   <= {DW{1'b0}};
            store_q <= {DW{1'b0}};
            wreg_q  <= {RW{1'b0}};
            tid_q   <= {TW{1'b0}};
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
            store_q <= store_d;
            wreg_q  <= wreg_d;
            tid_q   <= tid_d;
        end
    end

    assign bus.valid_out      = valid_q;
    assign bus.WRegEn_out     = ctrl_q.wreg_en;
    assign bus.WMemEn_out     = ctrl_q.wmem_en;
    assign bus.mem_to_reg_out = ctrl_q.mem_to_reg;
    assign bus.alu_result_out = alu_q;
    assign bus.store_data_out = store_q;
    assign bus.WReg1_out      = wreg_q;
    assign bus.thread_id_out  = tid_q;

`ifdef EX_PERF_CNT_EN
    logic [15:0] cnt_q [THREADS];
    logic [15:0] cnt_d [THREADS];

    // Retire counting; a clear on the same edge as a retire wins.
    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            cnt_d[t] = cnt_q[t];
            if (bus.perf_clr) begin
                cnt_d[t] = 16'h0000;
            end else if (load_s && (bus.thread_id_in == TW'(t))) begin
                cnt_d[t] = cnt_q[t] + 16'h0001;
            end else begin
                cnt_d[t] = cnt_q[t];
            end
        end
    end

    // Retire counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int t = 0; t < THREADS; t++) begin
                cnt_q[t] <= 16'h0000;
            end
        end else begin
            for (int t = 0; t < THREADS; t++) begin
                cnt_q[t] <= cnt_d[t];
            end
        end
    end

    assign bus.perf_count = cnt_q[bus.perf_sel];
`else
    logic unused_perf_s;
    assign unused_perf_s  = ^{bus.perf_sel, bus.perf_clr};
    assign bus.perf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: expected EX/MEM contents are queued when stimulus is driven
// and popped one cycle later; retire counts are tracked by a small per-thread model.
module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [15:0] alu;
        logic [15:0] store;
        logic        wen;
        logic        men;
        logic        m2r;
        logic [4:0]  wreg;
        logic [1:0]  tid;
    } exp_t;

    logic CLK;
    logic RST_N;
    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    logic [15:0] model_cnt [4];

    ex_mem_stage_if #(.DW(16), .RW(5), .TW(2)) bus ();

    ex_mem_stage dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_perf();
`ifdef EX_PERF_CNT_EN
        return model_cnt[bus.perf_sel];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic drive(input logic v, input logic wen, input logic men, input logic src,
                         input logic m2r, input logic [15:0] r1, input logic [15:0] r2,
                         input logic [15:0] se, input logic [4:0] wreg, input logic [2:0] f3,
                         input logic f7, input logic [1:0] tid);
        bus.valid_in      = v;
        bus.WRegEn_in     = wen;
        bus.WMemEn_in     = men;
        bus.alu_src_in    = src;
        bus.mem_to_reg_in = m2r;
        bus.R1out_in      = r1;
        bus.R2out_in      = r2;
        bus.sign_ext_in   = se;
        bus.WReg1_in      = wreg;
        bus.func3_in      = f3;
        bus.func7_in      = f7;
        bus.thread_id_in  = tid;
        bus.perf_sel      = tid;
    endtask

    task automatic expect_o(input logic v, input logic [15:0] alu, input logic [15:0] st,
                            input logic wen, input logic men, input logic m2r,
                            input logic [4:0] wreg, input logic [1:0] tid);
        exp_t e;
        e = '{valid: v, alu: alu, store: st, wen: wen, men: men, m2r: m2r, wreg: wreg, tid: tid};
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".valid"}, 16'(bus.valid_out),      16'(e.valid));
        chk({tag, ".alu"},   bus.alu_result_out,      e.alu);
        chk({tag, ".store"}, bus.store_data_out,      e.store);
        chk({tag, ".wen"},   16'(bus.WRegEn_out),     16'(e.wen));
        chk({tag, ".men"},   16'(bus.WMemEn_out),     16'(e.men));
        chk({tag, ".m2r"},   16'(bus.mem_to_reg_out), 16'(e.m2r));
        chk({tag, ".wreg"},  16'(bus.WReg1_out),      16'(e.wreg));
        chk({tag, ".tid"},   16'(bus.thread_id_out),  16'(e.tid));
    endtask

    // Advance one edge, updating the retire model from the inputs that edge samples.
    task automatic tick();
        logic       clr;
        logic       ret;
        logic [1:0] tid;
        clr = bus.perf_clr;
        ret = bus.valid_in & ~bus.flush & ~bus.stall;
        tid = bus.thread_id_in;
        @(posedge CLK);
        #1;
        if (clr) begin
            for (int t = 0; t < 4; t++) model_cnt[t] = 16'h0000;
        end else if (ret) begin
            model_cnt[tid] = model_cnt[tid] + 16'h0001;
        end
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        tick();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_out(tag, e);
        end
        chk({tag, ".perf"}, bus.perf_count, exp_perf());
    endtask

    task automatic check_reset(input string tag);
        exp_t z;
        z = '0;
        check_out(tag, z);
        chk({tag, ".perf"}, bus.perf_count, 16'h0000);
    endtask

    initial begin
        for (int t = 0; t < 4; t++) model_cnt[t] = 16'h0000;
        RST_N = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.perf_clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0, 3'b000, 1'b0, 2'd0);
        #12;
        check_reset("rst");
        RST_N = 1'b1;

        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 5'd5, ALU_ADD, 1'b0, 2'd1);
        expect_o(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 5'd5, 2'd1);
        cycle("add_ovf");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 5'd6, ALU_ADD, 1'b1, 2'd2);
        expect_o(1'b1, 16'h7FFE, 16'h0001, 1'b1, 1'b0, 1'b0, 5'd6, 2'd2);
        cycle("sub");
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8000, 16'h1234, 16'h0004, 5'd7, ALU_SRL, 1'b1, 2'd3);
        expect_o(1'b1, 16'hF800, 16'h1234, 1'b1, 1'b0, 1'b0, 5'd7, 2'd3);
        cycle("sra");
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8000, 16'h1234, 16'h0004, 5'd7, ALU_SRL, 1'b0, 2'd3);
        expect_o(1'b1, 16'h0800, 16'h1234, 1'b1, 1'b0, 1'b0, 5'd7, 2'd3);
        cycle("srl");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 5'd8, ALU_SLT, 1'b0, 2'd0);
        expect_o(1'b1, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 5'd8, 2'd0);
        cycle("slt");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 5'd8, ALU_SLTU, 1'b0, 2'd0);
        expect_o(1'b1, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 5'd8, 2'd0);
        cycle("sltu");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 16'hAAAA, 16'hFFFC, 5'd0, ALU_ADD, 1'b1, 2'd0);
        expect_o(1'b1, 16'h000C, 16'hAAAA, 1'b0, 1'b1, 1'b1, 5'd0, 2'd0);
        cycle("r0_imm");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0000, 5'd10, ALU_SLL, 1'b0, 2'd1);
        expect_o(1'b1, 16'h0030, 16'h0004, 1'b1, 1'b0, 1'b0, 5'd10, 2'd1);
        cycle("sll");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF0F0, 16'h0FF0, 16'h0000, 5'd11, ALU_XOR, 1'b0, 2'd2);
        expect_o(1'b1, 16'hFF00, 16'h0FF0, 1'b1, 1'b0, 1'b0, 5'd11, 2'd2);
        cycle("xor");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF0F0, 16'h0FF0, 16'h0000, 5'd12, ALU_AND, 1'b0, 2'd3);
        expect_o(1'b1, 16'h00F0, 16'h0FF0, 1'b1, 1'b0, 1'b0, 5'd12, 2'd3);
        cycle("and");

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0022, 16'h0000, 5'd9, ALU_ADD, 1'b0, 2'd2);
        expect_o(1'b1, 16'h0033, 16'h0022, 1'b1, 1'b1, 1'b0, 5'd9, 2'd2);
        cycle("pre_stall");
        bus.stall = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222, 16'h0000, 5'd4, ALU_OR, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            expect_o(1'b1, 16'h0033, 16'h0022, 1'b1, 1'b1, 1'b0, 5'd9, 2'd2);
            cycle("stall_hold");
        end
        bus.flush = 1'b1;
        expect_o(1'b0, 16'h0033, 16'h0022, 1'b0, 1'b0, 1'b0, 5'd9, 2'd2);
        cycle("stall_flush");
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5555, 16'h6666, 16'h0000, 5'd3, ALU_OR, 1'b0, 2'd3);
        expect_o(1'b0, 16'h0033, 16'h0022, 1'b0, 1'b0, 1'b0, 5'd9, 2'd2);
        cycle("bubble");
        bus.flush = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5555, 16'h6666, 16'h0000, 5'd3, ALU_OR, 1'b0, 2'd3);
        expect_o(1'b0, 16'h0033, 16'h0022, 1'b0, 1'b0, 1'b0, 5'd9, 2'd2);
        cycle("flush");
        bus.flush = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0023, 16'h0000, 5'd3, ALU_OR, 1'b0, 2'd1);
        expect_o(1'b1, 16'h0123, 16'h0023, 1'b1, 1'b0, 1'b0, 5'd3, 2'd1);
        cycle("or");

        // Asynchronous reset in the middle of a stall, checked before any clock edge.
        bus.stall = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        for (int t = 0; t < 4; t++) model_cnt[t] = 16'h0000;
        check_reset("async_rst");
        @(posedge CLK);
        #1;
        check_reset("rst_held");
        bus.stall = 1'b0;
        RST_N = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0003, 16'h0000, 5'd1, ALU_ADD, 1'b0, 2'd2);
        expect_o(1'b1, 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b0, 5'd1, 2'd2);
        cycle("post_rst");

`ifdef EX_PERF_CNT_EN
        bus.perf_sel = 2'd2;
        bus.perf_clr = 1'b1;
        bus.valid_in = 1'b0;
        tick();
        bus.perf_clr = 1'b0;
        chk("perf_clr", bus.perf_count, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0000, 5'd2, ALU_ADD, 1'b0, 2'd2);
        for (int i = 0; i < 65535; i++) tick();
        chk("perf_ffff", bus.perf_count, 16'hFFFF);
        tick();
        chk("perf_wrap", bus.perf_count, 16'h0000);
        chk("perf_wrap_model", bus.perf_count, exp_perf());
        tick();
        chk("perf_one", bus.perf_count, 16'h0001);
        bus.perf_clr = 1'b1;
        tick();
        bus.perf_clr = 1'b0;
        chk("perf_clr_wins", bus.perf_count, 16'h0000);
        bus.perf_sel = 2'd1;
        #1;
        chk("perf_other", bus.perf_count, 16'h0000);
`endif

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
